rx_cpu_gate: RTL and testbench

- Admission stage directly upstream of the CPU receive packet buffer.
- Takes each stored packet from the network-side store-and-forward FIFO together with its length descriptor, then presents the length to the buffer.
- Waits for the buffer's write-allowed flag, then either forwards the whole packet or drains and drops it.
- Keeps drop and length-error statistics for the CPU register block.

---
 rtl/rx_cpu_gate_pkg.sv | 18 +
 rtl/eth_pkt_if.sv | 12 +
 rtl/sat_counter.sv | 27 ++
 rtl/rx_cpu_gate.sv | 143 ++++++++++++++
 tb/tb_rx_cpu_gate.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_cpu_gate_pkg.sv
// Shared definitions for the CPU receive admission gate: FSM encoding,
// counter width default and the eop byte-count helper.
package rx_cpu_gate_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_DECIDE = 3'd2;
  localparam logic [2:0] ST_FWD    = 3'd3;
  localparam logic [2:0] ST_DROP   = 3'd4;

  // An eop word with mod=0 carries a full 8 bytes.
  function automatic logic [3:0] mod_bytes(input logic [2:0] mod);
    return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
  endfunction

endpackage

// File: rtl/eth_pkt_if.sv
// 64-bit showahead packet stream with byte-granular eop modulo.
interface eth_pkt_if;
  logic [63:0] data;
  logic        sop;
  logic        eop;
  logic [2:0]  mod;
  logic        val;
  logic        ready;

  modport i (input data, sop, eop, mod, val, output ready);
  modport o (output data, sop, eop, mod, val, input ready);
endinterface

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all ones; clear takes priority over increment.
module sat_counter
  import rx_cpu_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/rx_cpu_gate.sv
// Admission stage in front of the CPU receive buffer: presents each packet's
// length, waits for write-allowed, then forwards or drains the packet.
module rx_cpu_gate
  import rx_cpu_gate_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 4096,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  eth_pkt_if.i             pkt_i,
  input  logic [15:0]      len_i,
  input  logic             len_val_i,
  output logic             len_rd_o,
  input  logic [15:0]      cpu_mtu_i,
  input  logic             pkt_wa_i,
  output logic [15:0]      pkt_size_o,
  eth_pkt_if.o             pkt_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] drop_mtu_cnt_o,
  output logic [CNT_W-1:0] drop_tmo_cnt_o,
  output logic [CNT_W-1:0] len_err_cnt_o
);

  localparam int WT_W = $clog2(WAIT_TIMEOUT);

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [15:0]     r_pkt_size;
  logic [WT_W-1:0] r_wait;
  logic [16:0]     r_byte_cnt;

  logic        w_in_fire;
  logic        w_eop_fire;
  logic        w_wait_last;
  logic [16:0] w_byte_sum;
  logic        w_inc_mtu;
  logic        w_inc_tmo;
  logic        w_inc_err;

  assign w_in_fire   = pkt_i.val & pkt_i.ready;
  assign w_eop_fire  = w_in_fire & pkt_i.eop;
  assign w_wait_last = (r_wait == WT_W'(WAIT_TIMEOUT - 1));
  assign w_byte_sum  = r_byte_cnt + (pkt_i.eop ? 17'(mod_bytes(pkt_i.mod)) : 17'd8);

  assign w_inc_mtu = (r_state == ST_IDLE) && len_val_i && (len_i > cpu_mtu_i);
  assign w_inc_tmo = (r_state == ST_DECIDE) && !pkt_wa_i && w_wait_last;
  assign w_inc_err = (r_state == ST_FWD) && w_eop_fire && (w_byte_sum != {1'b0, r_pkt_size});

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (len_val_i) begin
          w_state_nxt = (len_i > cpu_mtu_i) ? ST_DROP : ST_SETTLE;
        end
      end
      ST_SETTLE: w_state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (pkt_wa_i) begin
          w_state_nxt = ST_FWD;
        end else if (w_wait_last) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_FWD, ST_DROP: begin
        if (w_eop_fire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_pkt_size <= '0;
      r_wait     <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          r_byte_cnt <= '0;
          if (len_val_i) begin
            r_pkt_size <= len_i;
          end
        end
        ST_SETTLE: r_wait <= '0;
        ST_DECIDE: begin
          if (!pkt_wa_i) begin
            r_wait <= r_wait + WT_W'(1);
          end
        end
        ST_FWD: begin
          if (w_in_fire) begin
            r_byte_cnt <= w_byte_sum;
          end
        end
        default: ;
      endcase
    end
  end

  // The stream is a pure wire in FWD; DROP sinks it without presenting it.
  assign pkt_o.data  = pkt_i.data;
  assign pkt_o.sop   = pkt_i.sop;
  assign pkt_o.eop   = pkt_i.eop;
  assign pkt_o.mod   = pkt_i.mod;
  assign pkt_o.val   = (r_state == ST_FWD) & pkt_i.val;
  assign pkt_i.ready = (r_state == ST_FWD) ? pkt_o.ready : (r_state == ST_DROP);

  // Popping on the eop edge lets IDLE see the next descriptor in the very next cycle.
  assign len_rd_o   = ((r_state == ST_FWD) || (r_state == ST_DROP)) & w_eop_fire;
  assign pkt_size_o = r_pkt_size;

  sat_counter #(.CNT_W(CNT_W)) u_drop_mtu (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (w_inc_mtu),
    .cnt_o (drop_mtu_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (w_inc_tmo),
    .cnt_o (drop_tmo_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_len_err (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (w_inc_err),
    .cnt_o (len_err_cnt_o)
  );

endmodule

// File: tb/tb_rx_cpu_gate.sv
// Scoreboard bench for rx_cpu_gate: a queue-based upstream FIFO model feeds the
// gate, expected output words and counter values come from the packet rules.
module tb_rx_cpu_gate;
  localparam int WAIT_TIMEOUT = 16;
  localparam int CNT_W        = 4;
  localparam int NEVER        = 32'h7fff_ffff;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  eth_pkt_if pkt_in ();
  eth_pkt_if pkt_out ();

  logic [15:0]      len_i;
  logic             len_val_i;
  logic             len_rd_o;
  logic [15:0]      cpu_mtu_i;
  logic             pkt_wa_i;
  logic [15:0]      pkt_size_o;
  logic             cnt_clr_i;
  logic [CNT_W-1:0] drop_mtu_cnt_o;
  logic [CNT_W-1:0] drop_tmo_cnt_o;
  logic [CNT_W-1:0] len_err_cnt_o;

  rx_cpu_gate #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pkt_i          (pkt_in),
    .len_i          (len_i),
    .len_val_i      (len_val_i),
    .len_rd_o       (len_rd_o),
    .cpu_mtu_i      (cpu_mtu_i),
    .pkt_wa_i       (pkt_wa_i),
    .pkt_size_o     (pkt_size_o),
    .pkt_o          (pkt_out),
    .cnt_clr_i      (cnt_clr_i),
    .drop_mtu_cnt_o (drop_mtu_cnt_o),
    .drop_tmo_cnt_o (drop_tmo_cnt_o),
    .len_err_cnt_o  (len_err_cnt_o)
  );

  word_t       src_q[$];
  logic [15:0] len_q[$];
  word_t       exp_q[$];

  int cyc = 0;
  int wa_rise_at = 0;
  int clr_at = -1;
  int ready_pct = 100;
  int sop_fire_cyc = -1;
  bit fire_prev = 1'b0;
  bit lenrd_prev = 1'b0;
  bit mon_en = 1'b0;

  int total = 0;
  int bad = 0;
  int exp_mtu = 0;
  int exp_tmo = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < (1 << CNT_W) - 1) ? v + 1 : v;
  endfunction

  // Upstream FIFOs and CPU-buffer model, driven at the falling edge.
  initial begin
    pkt_in.data = '0;
    pkt_in.sop  = 1'b0;
    pkt_in.eop  = 1'b0;
    pkt_in.mod  = '0;
    pkt_in.val  = 1'b0;
    pkt_out.ready = 1'b1;
    len_i     = '0;
    len_val_i = 1'b0;
    pkt_wa_i  = 1'b1;
    cnt_clr_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (fire_prev && src_q.size() > 0) void'(src_q.pop_front());
      if (lenrd_prev && len_q.size() > 0) void'(len_q.pop_front());
      if (src_q.size() > 0) begin
        pkt_in.data = src_q[0].data;
        pkt_in.sop  = src_q[0].sop;
        pkt_in.eop  = src_q[0].eop;
        pkt_in.mod  = src_q[0].mod;
        pkt_in.val  = 1'b1;
      end else begin
        pkt_in.data = '0;
        pkt_in.sop  = 1'b0;
        pkt_in.eop  = 1'b0;
        pkt_in.mod  = '0;
        pkt_in.val  = 1'b0;
      end
      len_val_i     = (len_q.size() > 0);
      len_i         = len_val_i ? len_q[0] : 16'd0;
      pkt_out.ready = ($urandom_range(99) < ready_pct);
      pkt_wa_i      = (cyc >= wa_rise_at);
      cnt_clr_i     = (cyc == clr_at);
      #1;
      fire_prev  = pkt_in.val && pkt_in.ready;
      lenrd_prev = len_rd_o;
      if (fire_prev && pkt_in.sop) sop_fire_cyc = cyc;
    end
  end

  // Monitor: pops the scoreboard whenever the gate hands a word to the buffer.
  initial begin
    word_t w;
    bit    eop_fire;
    forever begin
      @(negedge clk_i);
      #1;
      if (mon_en) begin
        eop_fire = pkt_in.val && pkt_in.ready && pkt_in.eop;
        if (len_rd_o || eop_fire) check("len_rd_on_eop", 64'(len_rd_o), 64'(eop_fire));
        if (pkt_out.val && pkt_out.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_word", 64'(exp_q.size()), 64'd1);
          end else begin
            w = exp_q.pop_front();
            check("out_data", pkt_out.data, w.data);
            check("out_ctrl", 64'({pkt_out.sop, pkt_out.eop, pkt_out.mod}), 64'({w.sop, w.eop, w.mod}));
          end
        end
      end
    end
  end

  // Call at posedge+2: the descriptor appears at the next falling edge (cycle t0).
  task automatic send_pkt(input int len, input int nwords, input int lastmod,
                          input int wa_delay, input bit timed, output int t0);
    word_t w;
    int    bytes;
    bit    fwd;
    t0 = cyc + 1;
    bytes = 8 * (nwords - 1) + ((lastmod == 0) ? 8 : lastmod);
    if (timed) wa_rise_at = (wa_delay < 0) ? NEVER : t0 + 2 + wa_delay;
    fwd = (len <= int'(cpu_mtu_i)) && (wa_delay >= 0) && (wa_delay < WAIT_TIMEOUT);
    if (len > int'(cpu_mtu_i)) exp_mtu = sat_inc(exp_mtu);
    else if (!fwd) exp_tmo = sat_inc(exp_tmo);
    else if (bytes != len) exp_err = sat_inc(exp_err);
    len_q.push_back(16'(len));
    for (int i = 0; i < nwords; i++) begin
      w.data = {$urandom, $urandom};
      w.sop  = (i == 0);
      w.eop  = (i == nwords - 1);
      w.mod  = (i == nwords - 1) ? 3'(lastmod) : 3'($urandom_range(7));
      src_q.push_back(w);
      if (fwd) exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((src_q.size() != 0 || len_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk_i);
      n++;
    end
    check("drain_done", 64'(src_q.size() + len_q.size() + exp_q.size()), 64'd0);
    repeat (3) @(posedge clk_i);
    #2;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_drop_mtu"}, 64'(drop_mtu_cnt_o), 64'(exp_mtu));
    check({tag, "_drop_tmo"}, 64'(drop_tmo_cnt_o), 64'(exp_tmo));
    check({tag, "_len_err"},  64'(len_err_cnt_o),  64'(exp_err));
  endtask

  task automatic timed_pkt(input string tag, input int len, input int nwords, input int lastmod,
                           input int wa_delay, input int first_ofs);
    int t0;
    send_pkt(len, nwords, lastmod, wa_delay, 1'b1, t0);
    wait_idle();
    check({tag, "_first_word_cycle"}, 64'(sop_fire_cyc - t0), 64'(first_ofs));
  endtask

  initial begin
    int t0;
    int nw;
    int md;
    int bytes;
    int len;
    cpu_mtu_i = 16'd1518;
    repeat (4) @(posedge clk_i);
    #2;
    check("rst_pkt_size", 64'(pkt_size_o), 64'd0);
    check("rst_out_val", 64'(pkt_out.val), 64'd0);
    check("rst_in_ready", 64'(pkt_in.ready), 64'd0);
    check("rst_len_rd", 64'(len_rd_o), 64'd0);
    check_counters("rst");
    rst_i  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_i);
    #2;

    // Minimum latency: IDLE, SETTLE, DECIDE, then the first word.
    timed_pkt("fwd64", 64, 8, 0, 0, 3);
    check("fwd64_pkt_size", 64'(pkt_size_o), 64'd64);
    check_counters("fwd64");

    // Oversize goes straight from IDLE to DROP.
    timed_pkt("mtu_drop", 2000, 4, 0, 0, 1);
    timed_pkt("after_drop", 60, 8, 4, 0, 3);
    check_counters("mtu");

    // Write-allowed timeout and late grants.
    timed_pkt("timeout", 64, 8, 0, -1, 2 + WAIT_TIMEOUT);
    timed_pkt("wa_at_10", 64, 8, 0, 10, 13);
    timed_pkt("wa_at_last", 40, 5, 0, WAIT_TIMEOUT - 1, 2 + WAIT_TIMEOUT);
    check_counters("tmo");

    // Descriptor says 64 but 72 bytes arrive.
    timed_pkt("len_err", 64, 9, 0, 0, 3);
    check_counters("lenerr");

    // Backpressure on the buffer side, single-word packet, MTU boundary.
    wa_rise_at = 0;
    ready_pct  = 50;
    cpu_mtu_i  = 16'd64;
    send_pkt(8, 1, 0, 0, 1'b0, t0);
    send_pkt(64, 8, 0, 0, 1'b0, t0);
    send_pkt(65, 9, 1, 0, 1'b0, t0);
    send_pkt(8, 1, 0, 0, 1'b0, t0);
    send_pkt(29, 4, 5, 0, 1'b0, t0);
    wait_idle();
    check_counters("bp");

    // Random back-to-back traffic.
    ready_pct = 70;
    cpu_mtu_i = 16'd60;
    for (int p = 0; p < 40; p++) begin
      nw    = $urandom_range(1, 10);
      md    = $urandom_range(7);
      bytes = 8 * (nw - 1) + ((md == 0) ? 8 : md);
      len   = ($urandom_range(3) == 0) ? bytes + $urandom_range(1, 4) - 2 : bytes;
      send_pkt(len, nw, md, 0, 1'b0, t0);
    end
    wait_idle();
    check_counters("rand");

    // Saturation of the oversize counter.
    ready_pct = 100;
    cpu_mtu_i = 16'd1518;
    for (int p = 0; p < (1 << CNT_W) + 3; p++) send_pkt(2000, 1, 0, 0, 1'b0, t0);
    wait_idle();
    check("sat_drop_mtu", 64'(drop_mtu_cnt_o), 64'((1 << CNT_W) - 1));
    check_counters("sat");

    // Reset while forwarding a long packet.
    send_pkt(160, 20, 0, 0, 1'b1, t0);
    repeat (6) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_out_val", 64'(pkt_out.val), 64'd0);
    check("midrst_in_ready", 64'(pkt_in.ready), 64'd0);
    check("midrst_len_rd", 64'(len_rd_o), 64'd0);
    check("midrst_pkt_size", 64'(pkt_size_o), 64'd0);
    src_q.delete();
    len_q.delete();
    exp_q.delete();
    fire_prev  = 1'b0;
    lenrd_prev = 1'b0;
    exp_mtu = 0;
    exp_tmo = 0;
    exp_err = 0;
    check_counters("midrst");
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;

    // Clear coinciding with an oversize increment.
    timed_pkt("pre_clr", 64, 9, 0, 0, 3);
    send_pkt(3000, 2, 0, 0, 1'b1, t0);
    clr_at  = t0;
    exp_mtu = 0;
    exp_tmo = 0;
    exp_err = 0;
    wait_idle();
    check_counters("clr");
    clr_at = -1;
    timed_pkt("post_clr", 3000, 2, 0, 0, 1);
    check_counters("post_clr");

    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
